// File: rtl/energy_coeff_reader.sv
// ---------------------------------------------------------------------------
// energy_coeff_reader
//
// Fabric-side reader for the per-channel energy-calibration coefficient LUT.
// Each accepted photon event (channel, phase) issues one read on port A of the
// LUT RAM. The event travels alongside the read through a tracker shift
// register. When the RAM word is valid, the event and its word are written
// into an output FIFO. The FIFO head is presented as two signed coefficients.
// A credit rule keeps the FIFO from overflowing under downstream backpressure.
//
// Ports:
//   clk, rst_n            fabric clock (shared with RAM port A), async active-low reset
//   in_valid/in_ready     event stream handshake
//   in_chan, in_phase     event channel (RAM address) and signed phase
//   bram_en_a, bram_addr  RAM port A enable and read address (registered)
//   bram_we, bram_wr_data tied to zero; this port only reads
//   bram_rd_data          RAM read data, valid RD_LAT edges after the address edge
//   out_valid/out_ready   result stream handshake
//   out_chan, out_phase   event of the result at the FIFO head
//   out_c0, out_c1        low and high signed halves of the coefficient word
//   inflight              reads issued but not yet captured (debug)
//   overflow              sticky; a capture found the FIFO full
// ---------------------------------------------------------------------------
module energy_coeff_reader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned PHASE_W    = 16,
  parameter int unsigned RD_LAT     = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_chan,
  input  logic [PHASE_W-1:0]         in_phase,
  output logic                       bram_en_a,
  output logic                       bram_we,
  output logic [ADDR_W-1:0]          bram_addr,
  output logic [DATA_W-1:0]          bram_wr_data,
  input  logic [DATA_W-1:0]          bram_rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_chan,
  output logic [PHASE_W-1:0]         out_phase,
  output logic signed [DATA_W/2-1:0] out_c0,
  output logic signed [DATA_W/2-1:0] out_c1,
  output logic [2:0]                 inflight,
  output logic                       overflow
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_FW = PTR_W + 1;
  // Wide enough for fifo count plus inflight without wrapping.
  localparam int unsigned CNT_W  = PTR_W + 4;
  localparam int unsigned HALF_W = DATA_W / 2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  // r_run keeps in_ready low while reset is asserted and for the first edge
  // after release, even though the credit sum is zero then.
  logic                r_run;
  logic                r_bram_en_a;
  logic [ADDR_W-1:0]   r_bram_addr;

  // Tracker: stage 0 is loaded on the issue edge; the last stage being valid
  // marks the edge at which bram_rd_data belongs to that event.
  logic [RD_LAT-1:0]   r_trk_vld;
  logic [ADDR_W-1:0]   r_trk_chan  [RD_LAT];
  logic [PHASE_W-1:0]  r_trk_phase [RD_LAT];

  logic [2:0]          r_inflight;

  logic [ADDR_W-1:0]   r_f_chan  [FIFO_DEPTH];
  logic [PHASE_W-1:0]  r_f_phase [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_f_data  [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_FW-1:0]   r_cnt;
  logic                r_overflow;

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]    w_credit_sum;
  logic                w_issue;
  logic                w_capture;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;

  // Credit depends on registered state only, so in_ready never combinationally
  // follows in_valid or out_ready.
  assign w_credit_sum = CNT_W'(r_cnt) + CNT_W'(r_inflight);
  assign in_ready     = r_run && (w_credit_sum < CNT_W'(FIFO_DEPTH));

  assign w_issue   = in_valid && in_ready;
  assign w_capture = r_trk_vld[RD_LAT-1];
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_FW'(FIFO_DEPTH));
  assign w_pop     = !w_empty && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push    = w_capture && (!w_full || w_pop);

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_bram_en_a <= 1'b0;
      r_bram_addr <= '0;
      r_trk_vld   <= '0;
      r_inflight  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_run       <= 1'b1;

      r_bram_en_a <= w_issue;
      if (w_issue) begin
        r_bram_addr <= in_chan;
      end

      r_trk_vld[0] <= w_issue;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_trk_vld[i] <= r_trk_vld[i-1];
      end

      unique case ({w_issue, w_capture})
        2'b10:   r_inflight <= r_inflight + 3'd1;
        2'b01:   r_inflight <= r_inflight - 3'd1;
        default: r_inflight <= r_inflight;
      endcase

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_FW'(1);
        2'b01:   r_cnt <= r_cnt - CNT_FW'(1);
        default: r_cnt <= r_cnt;
      endcase

      // Should be unreachable under the credit rule; the entry is dropped.
      if (w_capture && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Payload storage: qualified by the valid bits above, so no reset needed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    r_trk_chan[0]  <= in_chan;
    r_trk_phase[0] <= in_phase;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      r_trk_chan[i]  <= r_trk_chan[i-1];
      r_trk_phase[i] <= r_trk_phase[i-1];
    end

    if (w_push) begin
      r_f_chan[r_wr_ptr]  <= r_trk_chan[RD_LAT-1];
      r_f_phase[r_wr_ptr] <= r_trk_phase[RD_LAT-1];
      r_f_data[r_wr_ptr]  <= bram_rd_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] w_head_data;

  // Payload is forced to zero when empty so the stale FIFO contents never
  // leak onto the outputs, including straight after reset.
  assign w_head_data  = w_empty ? '0 : r_f_data[r_rd_ptr];

  assign out_valid    = !w_empty;
  assign out_chan     = w_empty ? '0 : r_f_chan[r_rd_ptr];
  assign out_phase    = w_empty ? '0 : r_f_phase[r_rd_ptr];
  assign out_c0       = w_head_data[HALF_W-1:0];
  assign out_c1       = w_head_data[DATA_W-1:HALF_W];

  assign bram_en_a    = r_bram_en_a;
  assign bram_addr    = r_bram_addr;
  assign bram_we      = 1'b0;
  assign bram_wr_data = '0;

  assign inflight     = r_inflight;
  assign overflow     = r_overflow;

endmodule

// File: doc/energy_coeff_reader.md
Name: energy_coeff_reader

Overview:
- Fabric-side reader for the per-channel energy-calibration coefficient LUT. It drives the 64-bit read port (port A) of the LUT RAM block, whose port B is written by the PowerPC bus.
- Accepts photon events (channel, phase) on a valid/ready stream and issues one RAM read per event. Returns each event with its 64-bit coefficient word, split into two signed 32-bit coefficients, in order.
- Absorbs the fixed RAM read latency under downstream backpressure using an in-flight tracker, credit counting and an output FIFO.

Parameters:
- ADDR_W, 10, channel/RAM address width
- DATA_W, 64, RAM word width; coefficients are the two DATA_W/2 halves
- PHASE_W, 16, event phase width (signed, passed through)
- RD_LAT, 3, RAM read latency in cycles from address-present edge to valid data (core and primitive output registers both enabled)
- FIFO_DEPTH, 8, output FIFO entries; must be >= RD_LAT+1; power of two

Ports:
- clk  in  1  fabric clock, shared with the RAM port A
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  event valid
- in_ready  out  1  event accepted when in_valid && in_ready at a rising edge
- in_chan  in  ADDR_W  channel index, used as the RAM address
- in_phase  in  PHASE_W  event phase
- bram_en_a  out  1  RAM port A enable
- bram_we  out  1  RAM write enable; constant 0
- bram_addr  out  ADDR_W  RAM read address
- bram_wr_data  out  DATA_W  constant 0
- bram_rd_data  in  DATA_W  RAM read data
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_chan  out  ADDR_W  channel of the result
- out_phase  out  PHASE_W  phase of the result
- out_c0  out  DATA_W/2  bram_rd_data[DATA_W/2-1:0], signed
- out_c1  out  DATA_W/2  bram_rd_data[DATA_W-1:DATA_W/2], signed
- inflight  out  3  number of reads issued but not yet captured (debug)
- overflow  out  1  sticky error; set if a capture finds the FIFO full

Behaviour:
- Reset (async assert, sync deassert handled externally): all outputs are 0, with these values: in_ready=0, bram_en_a=0, bram_addr=0, out_valid=0, inflight=0, overflow=0. FIFO is empty, in-flight tracker is cleared, and FIFO contents are don't-care.
- Reset mid-operation drops all in-flight reads and FIFO contents. RAM data returning after reset is ignored because the tracker is cleared.
- Credit: in_ready = (fifo_count + inflight) < FIFO_DEPTH. It is combinational from registered state only; it never depends on in_valid or out_ready.
- Issue: on an accepting edge, bram_en_a<=1 and bram_addr<=in_chan, both registered. Otherwise bram_en_a<=0 and bram_addr holds.
- Tracker: a RD_LAT-deep shift register of {valid, chan, phase}, loaded at the issue edge. Stage RD_LAT valid marks the edge at which bram_rd_data is captured, i.e. RD_LAT edges after the address was presented.
- Capture writes {chan, phase, rd_data} into the FIFO at that edge.
- Latency: out_valid rises RD_LAT+1 edges after the accepting edge when the FIFO was empty.
- Throughput: 1 event/cycle sustained while out_ready=1.
- Output: out_* present the FIFO head; out_valid = !fifo_empty. The head is popped on out_valid && out_ready. out_* are stable while out_valid && !out_ready.
- Simultaneous capture and pop on a full FIFO is legal: the count is unchanged. Capture plus pop on a one-entry FIFO shows the new entry on the next cycle.
- inflight increments on issue and decrements on capture; both on the same edge leaves it unchanged.
- Ordering: results are strictly in acceptance order.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. The count is ADDR-independent and saturates never by construction.
- Credit rule guarantees capture never finds the FIFO full. If it does, the entry is dropped and overflow is set until reset.
- in_chan beyond populated LUT range: no check; the RAM word is returned as is.

Test Plan:
- Reset then single event chan=5, phase=-100, RAM[5]=64'h0000_0002_FFFF_FFFE, out_ready=1. Required: bram_addr=5 with en=1 for one cycle; out_valid at edge 4 after acceptance with out_c0=-2, out_c1=2, out_chan=5, out_phase=-100.
- Stream 64 back-to-back events, chan 0..63, out_ready=1. Required: in_ready stays 1, out_valid continuous from cycle 4, outputs in order, inflight peaks at 3.
- out_ready=0 with in_valid held. Required: exactly 8 events accepted, in_ready=0 afterwards, overflow=0. Then out_ready=1: 8 results in order, and in_ready reasserts one cycle after the first pop.
- Random in_valid/out_ready at 50% each over 10k events against a scoreboard. Required: no loss, no duplication, order preserved, overflow=0, out_* stable while stalled.
- Assert rst_n low with inflight=3 and 5 FIFO entries. Required: all outputs 0 immediately; after release, the first event gives the correct single result with no stale data.
- Verify bram_we=0 and bram_wr_data=0 throughout.
